pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Consumer end of the PLL lock interface: runs in the PLL output clock domain, takes the raw
//  (asynchronous) lock flag and produces a clean synchronous system reset for downstream logic.
//  Filters lock glitches, stretches reset after lock, and re-sequences on lock loss.
//  Sits between the PLL wrapper and all video/CPU logic clocked from the PLL output.
// PARAMETERS
//  LOCK_FILTER   4   consecutive synced-lock-high cycles required before leaving WAIT_LOCK (>=1)
//  RESET_CYCLES  8   cycles sys_reset held in STRETCH after lock is accepted (>=1)
//  CNT_W         8   width of lock-loss counter (saturating)
// PORTS
//  clk             in   1      PLL output clock; sole clock of the block
//  reset           in   1      synchronous, active-high; external/board reset already in clk domain
//  pll_locked      in   1      raw PLL lock flag, asynchronous to clk
//  sys_reset       out  1      synchronous active-high reset to downstream logic (registered)
//  ready           out  1      high only in RUN (registered, == ~sys_reset)
//  lock_loss_count out  CNT_W  number of RUN->WAIT_LOCK lock drops since reset, saturates at all-ones
//  state           out  2      current FSM state, for debug
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset values: sys_reset=1, ready=0,
//    lock_loss_count=0, state=WAIT_LOCK, filter/stretch counters=0, both sync flops=0.
//  - pll_locked passes a 2-flop synchroniser -> lk_s; lk_s lags pll_locked by 2 cycles.
//  - States: WAIT_LOCK=0, STRETCH=1, RUN=2 (3 unused -> treated as WAIT_LOCK next cycle).
//  - WAIT_LOCK: sys_reset=1. filt counts consecutive lk_s=1 cycles; lk_s=0 clears filt.
//    When filt reaches LOCK_FILTER -> STRETCH, stretch counter cleared.
//  - STRETCH: sys_reset=1; counter increments each cycle; after RESET_CYCLES cycles -> RUN.
//    lk_s=0 in STRETCH -> WAIT_LOCK, filt=0, no lock-loss increment.
//  - RUN: sys_reset=0, ready=1. lk_s=0 -> WAIT_LOCK next cycle; sys_reset=1 on that same edge
//    (one register stage, no extra delay); lock_loss_count += 1 unless already all-ones.
//  - Latency: pll_locked stable high from edge 0 -> sys_reset low after exactly
//    2 + LOCK_FILTER + RESET_CYCLES edges (14 with defaults). Lock drop in RUN -> sys_reset
//    high 3 edges after pll_locked falls (2 sync + 1 FSM).
//  - Simultaneous events: reset dominates everything. Lock drop in the cycle RUN would be
//    entered (last STRETCH cycle with lk_s=0) -> WAIT_LOCK, no count. Counter saturation:
//    lock_loss_count stays all-ones, never wraps.
//  - Reset mid-operation (any state): next edge returns to reset values; lock_loss_count cleared.
//  - Glitches on pll_locked shorter than LOCK_FILTER synced cycles never release sys_reset.
//  - Counters sized $clog2(max(LOCK_FILTER,RESET_CYCLES)+1); no overflow possible.
// STRUCTURE
//  - Shared defs include (reset_seq_defs.vh): state encodings WAIT_LOCK/STRETCH/RUN, state width.
//  - One sub-module: sync_2ff (2-flop bit synchroniser, sync reset to 0), reusable elsewhere.
//  - Top: FSM + filter counter + stretch counter + saturating loss counter; all outputs registered.
//  - Under `sim the PLL wrapper ties lock high; this block needs no sim special-casing.
// TESTING
//  1 Reset then pll_locked=1 from cycle 0 (defaults) -> sys_reset low, ready high at edge 14 exactly.
//  2 pll_locked pulses high 3 cycles, low 1, repeated 10x -> sys_reset never deasserts, count=0.
//  3 In RUN drop pll_locked for 1 cycle -> sys_reset high 3 edges later, count=1,
//    re-release 14 edges after lock returns.
//  4 Drop lock during STRETCH (edge 9) -> back to WAIT_LOCK, count stays 0, ready never pulses.
//  5 CNT_W=2, 5 RUN lock drops -> count 1,2,3,3,3 (saturates, no wrap).
//  6 Assert reset for 1 cycle while in RUN with count=2 -> sys_reset=1, count=0, state=WAIT_LOCK
//    next edge; pll_locked held high -> release 14 edges after reset deasserts.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and counter sizing.
package pll_reset_sequencer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STRETCH   = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  // Width that holds max(a, b) without overflow.
  function automatic int unsigned ctr_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop single-bit synchroniser with synchronous active-high reset to 0.
module pll_reset_sequencer_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock flag into a filtered, stretched synchronous system reset
// and re-sequences from scratch whenever lock is lost.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_FILTER  = 4,
  parameter int unsigned RESET_CYCLES = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  output logic               sys_reset,
  output logic               ready,
  output logic [CNT_W-1:0]   lock_loss_count,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned CTR_W = ctr_width(LOCK_FILTER, RESET_CYCLES);
  localparam logic [CTR_W-1:0] FILT_LAST    = CTR_W'(LOCK_FILTER - 1);
  localparam logic [CTR_W-1:0] STRETCH_LAST = CTR_W'(RESET_CYCLES - 1);

  logic             w_lk_s;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CTR_W-1:0] r_filt;
  logic [CTR_W-1:0] w_filt_nxt;
  logic [CTR_W-1:0] r_stretch;
  logic [CTR_W-1:0] w_stretch_nxt;
  logic [CNT_W-1:0] r_loss;
  logic [CNT_W-1:0] w_loss_nxt;
  logic             r_sys_reset;
  logic             w_sys_reset_nxt;
  logic             r_ready;
  logic             w_ready_nxt;

  pll_reset_sequencer_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (pll_locked),
    .o_q   (w_lk_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_WAIT_LOCK;
      r_filt      <= '0;
      r_stretch   <= '0;
      r_loss      <= '0;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_filt      <= w_filt_nxt;
      r_stretch   <= w_stretch_nxt;
      r_loss      <= w_loss_nxt;
      r_sys_reset <= w_sys_reset_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  // Counters idle at zero outside their own state, so every re-entry starts clean.
  always_comb begin
    w_state_nxt   = r_state;
    w_filt_nxt    = '0;
    w_stretch_nxt = '0;
    w_loss_nxt    = r_loss;
    unique case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lk_s) begin
          if (r_filt == FILT_LAST) begin
            w_state_nxt = ST_STRETCH;
          end else begin
            w_filt_nxt = r_filt + CTR_W'(1);
          end
        end
      end
      ST_STRETCH: begin
        // Lock loss wins over the final stretch cycle and is not counted.
        if (!w_lk_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_stretch == STRETCH_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stretch_nxt = r_stretch + CTR_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lk_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          if (r_loss != '1) begin
            w_loss_nxt = r_loss + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
    endcase
    w_sys_reset_nxt = (w_state_nxt != ST_RUN);
    w_ready_nxt     = (w_state_nxt == ST_RUN);
  end

  assign sys_reset       = r_sys_reset;
  assign ready           = r_ready;
  assign lock_loss_count = r_loss;
  assign state           = r_state;

endmodule
